// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master FSM states.
// Pure declarations, no logic and no latency.
// Used by the command master and by the AXI4-Lite memory slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one cmd in, one AXI write/read out, one rsp back.
// Latency: AXI VALID one cycle after cmd accept; rsp_valid one cycle after the B/R handshake.
// Backpressure: cmd_ready only in IDLE; rsp payload held until rsp_ready; AXI VALIDs held until READY.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  // status
  output logic [CNT_W-1:0]    txn_count,
  output logic [CNT_W-1:0]    err_count
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_write;
  logic [DATA_W-1:0]     r_rdata;
  logic [1:0]            r_resp;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [CNT_W-1:0]      r_txn;
  logic [CNT_W-1:0]      r_err;

  // Handshakes derived from state/flags directly so the FSM block never reads its own outputs.
  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rsp_hs;

  assign w_cmd_hs = (r_state == IDLE) && arst_n && cmd_valid;
  assign w_aw_hs  = (r_state == WR_REQ) && !r_aw_done && M_AXI_AWREADY;
  assign w_w_hs   = (r_state == WR_REQ) && !r_w_done && M_AXI_WREADY;
  assign w_b_hs   = (r_state == WR_RESP) && M_AXI_BVALID;
  assign w_ar_hs  = (r_state == RD_REQ) && M_AXI_ARREADY;
  assign w_r_hs   = (r_state == RD_RESP) && M_AXI_RVALID;
  assign w_rsp_hs = (r_state == RSP) && rsp_ready;

  // Payload outputs come straight from the latched command, so they cannot move mid-handshake.
  assign M_AXI_AWADDR = r_addr;
  assign M_AXI_ARADDR = r_addr;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = r_wstrb;
  assign rsp_write    = r_write;
  assign rsp_rdata    = r_rdata;
  assign rsp_resp     = r_resp;
  assign txn_count    = r_txn;
  assign err_count    = r_err;

  // State register; reset returns to IDLE and discards any in-flight transaction.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; cmd_ready is gated by reset so it reads 0 while held in reset.
  always_comb begin
    w_next        = r_state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = arst_n;
        if (cmd_valid && arst_n) begin
          w_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        M_AXI_AWVALID = !r_aw_done;
        M_AXI_WVALID  = !r_w_done;
        // A channel is finished if already done or its READY is up while VALID is shown.
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) begin
          w_next = WR_RESP;
        end
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          w_next = RSP;
        end
      end
      RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          w_next = RD_RESP;
        end
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          w_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch command, track AW/W completion, capture the response, count completions.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_txn     <= '0;
      r_err     <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_write   <= cmd_write;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if (w_b_hs) begin
        r_resp  <= M_AXI_BRESP;
        r_rdata <= '0;
      end
      if (w_r_hs) begin
        r_resp  <= M_AXI_RRESP;
        r_rdata <= M_AXI_RDATA;
      end
      if (w_rsp_hs) begin
        r_txn <= r_txn + CNT_W'(1);
        if (r_resp != RESP_OKAY) begin
          r_err <= r_err + CNT_W'(1);
        end
      end
    end
  end

  // Write handshakes and read handshakes are mutually exclusive by state.
  logic w_unused;
  assign w_unused = w_ar_hs;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: behavioural AXI4-Lite memory slave with programmable
// READY/VALID delays, a word-level reference memory giving expected responses, and
// protocol monitors for VALID hold, payload stability and cmd_ready exclusivity.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int LIM = 50;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic          arvalid, arready = 0, rvalid = 0, rready;
  logic [DW-1:0] wdata, rdata = '0;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = 0, rresp = 0;
  logic [CW-1:0] txn_count, err_count;

  axi_lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .txn_count(txn_count), .err_count(err_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address map shared by the slave and the reference: bit9 -> DECERR, bit8 -> SLVERR, else RAM.
  function automatic logic [1:0] map_resp(input logic [31:0] a);
    if (a[9]) return RESP_DECERR;
    if (a[8]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [31:0] smem   [0:63];
  logic [31:0] ref_mem[0:63];
  int exp_txn = 0, exp_err = 0;

  // Slave configuration (cycles of READY-low while VALID shown; response delays; early READY).
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit aw_early = 0, w_early = 0, ar_early = 0;

  // Monitor state, sampled on posedge (pre-edge values).
  int cyc = 0, resp_hs_cyc = -10;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] cap_aw, cap_wd, cap_ar;
  logic [3:0]  cap_ws;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_awv = 0, n_wv = 0;
  int viol_hold = 0, viol_excl = 0;
  bit p_aw, p_w, p_ar;
  logic [31:0] p_awa, p_wd, p_ara;
  logic [3:0]  p_ws;

  always @(posedge clk) begin
    cyc++;
    if (!arst_n) begin
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
      hs_ar = arvalid && arready; hs_r = rvalid && rready;
      cap_aw = awaddr; cap_wd = wdata; cap_ws = wstrb; cap_ar = araddr;
      if (hs_aw) n_aw++;
      if (hs_w) n_w++;
      if (hs_b) n_b++;
      if (hs_ar) n_ar++;
      if (hs_r) n_r++;
      if (awvalid) n_awv++;
      if (wvalid) n_wv++;
      if (hs_b || hs_r) resp_hs_cyc = cyc;
      if (p_aw && (!awvalid || awaddr !== p_awa)) viol_hold++;
      if (p_w && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) viol_hold++;
      if (p_ar && (!arvalid || araddr !== p_ara)) viol_hold++;
      if (cmd_ready && (awvalid || wvalid || arvalid || bready || rready || rsp_valid)) viol_excl++;
      if (bready && rready) viol_excl++;
      p_aw = awvalid && !awready; p_awa = awaddr;
      p_w = wvalid && !wready; p_wd = wdata; p_ws = wstrb;
      p_ar = arvalid && !arready; p_ara = araddr;
    end
  end

  // Behavioural memory slave, updating its outputs mid-cycle.
  bit aw_have, w_have, ar_have;
  logic [31:0] s_awa, s_wd, s_ara;
  logic [3:0]  s_ws;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;

  always @(negedge clk) begin
    if (!arst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_have = 0; w_have = 0; ar_have = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (hs_b) begin bvalid = 0; aw_have = 0; w_have = 0; b_wait = 0; end
      if (hs_r) begin rvalid = 0; ar_have = 0; r_wait = 0; end
      if (hs_aw) begin aw_have = 1; s_awa = cap_aw; aw_wait = 0; end
      if (hs_w) begin w_have = 1; s_wd = cap_wd; s_ws = cap_ws; w_wait = 0; end
      if (hs_ar) begin ar_have = 1; s_ara = cap_ar; ar_wait = 0; end
      if (aw_have) awready = 0;
      else if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
      else awready = aw_early;
      if (w_have) wready = 0;
      else if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
      else wready = w_early;
      if (ar_have) arready = 0;
      else if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
      else arready = ar_early;
      if (aw_have && w_have && !bvalid) begin
        if (b_wait >= b_dly) begin
          bvalid = 1; bresp = map_resp(s_awa);
          if (bresp == RESP_OKAY)
            for (int b = 0; b < 4; b++) if (s_ws[b]) smem[s_awa[7:2]][8*b +: 8] = s_wd[8*b +: 8];
        end else b_wait++;
      end
      if (ar_have && !rvalid) begin
        if (r_wait >= r_dly) begin
          rvalid = 1; rresp = map_resp(s_ara);
          rdata = (rresp == RESP_OKAY) ? smem[s_ara[7:2]] : 32'h0;
        end else r_wait++;
      end
    end
  end

  // Word-level reference: expected rsp_rdata/rsp_resp for one command.
  task automatic ref_apply(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] er, output logic [1:0] eresp);
    eresp = map_resp(a);
    er = 32'h0;
    if (eresp == RESP_OKAY) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        er = ref_mem[a[7:2]];
      end
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] got_d, output logic [1:0] got_r);
    logic [31:0] er, sd;
    logic [1:0]  eresp, sr;
    logic        sw;
    bit          stable;
    int          n, b_aw, b_w, b_b, b_ar, b_r;
    got_d = 'x; got_r = 'x;
    ref_apply(wr, a, d, s, er, eresp);
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < LIM) begin @(negedge clk); n++; end
    check("cmd_accept_timeout", n < LIM, 1);
    if (n >= LIM) begin cmd_valid = 0; return; end
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    if (wr) begin
      check("first_aw_w_valid", {awvalid, wvalid}, 2'b11);
      check("awaddr", awaddr, a);
      check("wdata", wdata, d);
      check("wstrb", wstrb, s);
    end else begin
      check("first_ar_valid", arvalid, 1);
      check("araddr", araddr, a);
    end
    check("busy_cmd_ready", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < LIM) begin @(negedge clk); n++; end
    check("rsp_timeout", n < LIM, 1);
    if (n >= LIM) return;
    check("rsp_latency", 64'(cyc - resp_hs_cyc), 0);
    sd = rsp_rdata; sr = rsp_resp; sw = rsp_write; stable = 1;
    for (int i = 0; i < hold; i++) begin
      if (!rsp_valid || rsp_rdata !== sd || rsp_resp !== sr || rsp_write !== sw ||
          cmd_ready || awvalid || wvalid || arvalid) stable = 0;
      @(negedge clk);
    end
    if (hold > 0) check("rsp_hold_stable", stable, 1);
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    got_d = sd; got_r = sr;
    check("rsp_write", sw, wr);
    check("rsp_rdata", sd, er);
    check("rsp_resp", sr, eresp);
    exp_txn = (exp_txn + 1) % (1 << CW);
    if (eresp != RESP_OKAY) exp_err = (exp_err + 1) % (1 << CW);
    check("txn_count", txn_count, exp_txn);
    check("err_count", err_count, exp_err);
    check("ready_after_rsp", cmd_ready, 1);
    check("axi_hs_counts",
          {4'(n_aw - b_aw), 4'(n_w - b_w), 4'(n_b - b_b), 4'(n_ar - b_ar), 4'(n_r - b_r)},
          wr ? 20'h11100 : 20'h00011);
  endtask

  task automatic slave_cfg(input int awd, input int wd, input int ard, input int bd, input int rd,
                           input bit awe, input bit we, input bit are);
    aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
    aw_early = awe; w_early = we; ar_early = are;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gd, a, d;
    logic [1:0]  gr;
    int          v0, w0;
    bit          we, ae, ke;
    for (int i = 0; i < 64; i++) begin smem[i] = 32'h0; ref_mem[i] = 32'h0; end

    // Reset values while held in reset.
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    check("rst_payload", {awaddr, wdata, wstrb, araddr}, 100'b0);
    check("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'b0);
    check("rst_counts", {txn_count, err_count}, 16'h0);
    @(negedge clk);
    arst_n = 1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write 0xDEADBEEF to 0x10, read it back.
    slave_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    do_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, gd, gr);
    do_cmd(0, 32'h10, 32'h0, 4'h0, 0, gd, gr);
    check("wr_rd_data", gd, 32'hDEADBEEF);
    check("wr_rd_resp", gr, RESP_OKAY);
    check("wr_rd_txn", txn_count, 2);
    check("wr_rd_err", err_count, 0);

    // AWREADY low for the first 3 AWVALID cycles, WREADY immediate.
    slave_cfg(3, 0, 0, 0, 0, 0, 0, 0);
    v0 = n_awv; w0 = n_wv;
    do_cmd(1, 32'h20, 32'h12345678, 4'hF, 0, gd, gr);
    check("aw_delay_awvalid_cycles", n_awv - v0, 4);
    check("aw_delay_wvalid_cycles", n_wv - w0, 1);

    // Response stalled 5 cycles.
    slave_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    do_cmd(0, 32'h20, 32'h0, 4'h0, 5, gd, gr);
    check("hold_rdata", gd, 32'h12345678);

    // Slave error on a read.
    do_cmd(0, 32'h110, 32'h0, 4'h0, 0, gd, gr);
    check("slverr_resp", gr, RESP_SLVERR);
    check("slverr_err_count", err_count, 1);

    // Randomized mix of traffic, slave timing and response stalls.
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1)); ae = 1'($urandom_range(0, 1)); ke = 1'($urandom_range(0, 1));
      slave_cfg(ae ? 0 : $urandom_range(0, 3), we ? 0 : $urandom_range(0, 3),
                ke ? 0 : $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ae, we, ke);
      a = 32'($urandom_range(0, 255)) << 2;
      d = $urandom;
      do_cmd(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), gd, gr);
    end

    // Asynchronous reset while a write is stuck in WR_REQ.
    slave_cfg(20, 20, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    check("pre_rst_awvalid", awvalid, 1);
    #2 arst_n = 0;
    #1;
    check("mid_rst_aw_w_valid", {awvalid, wvalid}, 2'b00);
    check("mid_rst_counts", {txn_count, err_count}, 16'h0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_others", {arvalid, bready, rready, rsp_valid, awaddr}, 36'h0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
    exp_txn = 0; exp_err = 0;
    @(negedge clk);
    check("post_rst2_idle", {cmd_ready, awvalid, wvalid, arvalid, rsp_valid}, 5'b10000);

    // Counter wrap: 2^CW + 1 back-to-back reads.
    slave_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < (1 << CW) + 1; k++) begin
      do_cmd(0, 32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0, 0, gd, gr);
    end
    check("txn_wrap", txn_count, 1);

    check("valid_hold_violations", viol_hold, 0);
    check("cmd_ready_exclusive_violations", viol_excl, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
